// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each operation is accepted in IDLE. Its operands are registered and
// presented to the ALU in EXEC. The result is latched and then held in
// HOLD until the owning requester takes it.
// Optional feature: define ALU_ARB_RR_EN to enable round-robin arbitration
// with a last_grant register. Without it, port 0 has fixed priority.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} stateT;

    stateT             state;
    stateT             stateNext;
    logic              winner;
    logic              accept;
    logic              anyValid;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;
    logic [OP_W-1:0]   opReg;
    logic [DATA_W-1:0] resultReg;
    logic              grantReg;

    assign anyValid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
    logic lastGrant;

    // Round-robin: on contention the port that did not win last time goes first
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid)
            winner = ~lastGrant;
        else if (req1_valid)
            winner = 1'b1;
    end

    // Remember the most recently accepted port; reset favours port 0 next
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lastGrant <= 1'b1;
        else if (accept)
            lastGrant <= winner;
    end
`else
    // Fixed priority: port 1 only wins when port 0 is idle
    always_comb begin
        winner = 1'b0;
        if (req1_valid && !req0_valid)
            winner = 1'b1;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic and request handshake; ready only ever asserted in IDLE
    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (anyValid) begin
                    accept     = 1'b1;
                    req0_ready = ~winner;
                    req1_ready = winner;
                    stateNext  = EXEC;
                end
            end
            EXEC: stateNext = HOLD;
            HOLD: begin
                if (grantReg ? rsp1_ready : rsp0_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture on acceptance and result capture in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aReg      <= '0;
            bReg      <= '0;
            opReg     <= '0;
            resultReg <= '0;
            grantReg  <= 1'b0;
        end else begin
            if (accept) begin
                aReg     <= winner ? req1_a  : req0_a;
                bReg     <= winner ? req1_b  : req0_b;
                opReg    <= winner ? req1_op : req0_op;
                grantReg <= winner;
            end
            if (state == EXEC)
                resultReg <= alu_result;
        end
    end

    // ALU is fed only from the registered operands, so requesters may change
    // their inputs once accepted
    assign alu_a    = aReg;
    assign alu_b    = bReg;
    assign alu_op   = opReg;
    assign grant_id = grantReg;

    // Response goes only to the owning port; the other port sees zero
    assign rsp0_valid  = (state == HOLD) && !grantReg;
    assign rsp1_valid  = (state == HOLD) && grantReg;
    assign rsp0_result = rsp0_valid ? resultReg : '0;
    assign rsp1_result = rsp1_valid ? resultReg : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with an adder ALU stub.
// Expectations for the arbitration sequence follow ALU_ARB_RR_EN.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0Valid, req0Ready, rsp0Valid, rsp0Ready;
    logic [31:0] req0A, req0B, rsp0Result;
    logic [3:0]  req0Op;
    logic        req1Valid, req1Ready, rsp1Valid, rsp1Ready;
    logic [31:0] req1A, req1B, rsp1Result;
    logic [3:0]  req1Op;
    logic [31:0] aluA, aluB, aluResult;
    logic [3:0]  aluOp;
    logic        grantId;

    int checks;
    int failures;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
        .rsp0_valid(rsp0Valid), .rsp0_ready(rsp0Ready), .rsp0_result(rsp0Result),
        .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
        .rsp1_valid(rsp1Valid), .rsp1_ready(rsp1Ready), .rsp1_result(rsp1Result),
        .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_result(aluResult),
        .grant_id(grantId)
    );

    assign aluResult = aluA + aluB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0Valid = 0; req0A = 0; req0B = 0; req0Op = 0; rsp0Ready = 0;
        req1Valid = 0; req1A = 0; req1B = 0; req1Op = 0; rsp1Ready = 0;
        #1;
        checks++; if (rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b%b want 00", rsp0Valid, rsp1Valid); end
        checks++; if (aluA !== 0 || aluB !== 0 || aluOp !== 0 || grantId !== 0) begin failures++; $display("FAIL reset_regs got a=%0d b=%0d op=%0d g=%0d want 0", aluA, aluB, aluOp, grantId); end
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_port0_alone();
        req0Valid = 1; req0A = 5; req0B = 7; req0Op = 0; rsp0Ready = 1;
        #1;
        checks++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin failures++; $display("FAIL p0_accept got r0=%b r1=%b want 1 0", req0Ready, req1Ready); end
        tick();
        req0Valid = 0;
        #1;
        checks++; if (rsp0Valid !== 1'b0 || req0Ready !== 1'b0 || aluA !== 5 || aluB !== 7) begin failures++; $display("FAIL p0_exec got v=%b rdy=%b a=%0d b=%0d want 0 0 5 7", rsp0Valid, req0Ready, aluA, aluB); end
        tick();
        checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 12) begin failures++; $display("FAIL p0_result got v=%b r=%0d want 1 12", rsp0Valid, rsp0Result); end
        checks++; if (rsp1Valid !== 1'b0 || rsp1Result !== 0) begin failures++; $display("FAIL p0_other_port got v=%b r=%0d want 0 0", rsp1Valid, rsp1Result); end
        tick();
        checks++; if (rsp0Valid !== 1'b0) begin failures++; $display("FAIL p0_back_idle rsp0_valid got %b want 0", rsp0Valid); end
        req0Valid = 1;
        #1;
        checks++; if (req0Ready !== 1'b1) begin failures++; $display("FAIL p0_idle_ready got %b want 1", req0Ready); end
        req0Valid = 0;
        #1;
        rsp0Ready = 0;
    endtask

    task automatic test_both_valid();
        logic expGrant [4];
`ifdef ALU_ARB_RR_EN
        expGrant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        expGrant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0Valid = 1; req0A = 1; req0B = 1; req0Op = 0; rsp0Ready = 1;
        req1Valid = 1; req1A = 2; req1B = 2; req1Op = 0; rsp1Ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req0Ready !== !expGrant[i] || req1Ready !== expGrant[i]) begin failures++; $display("FAIL both_ready[%0d] got r0=%b r1=%b want grant %0d", i, req0Ready, req1Ready, expGrant[i]); end
            tick(); tick();
            checks++; if (grantId !== expGrant[i]) begin failures++; $display("FAIL both_grant[%0d] got %0d want %0d", i, grantId, expGrant[i]); end
            if (expGrant[i]) begin
                checks++; if (rsp1Valid !== 1'b1 || rsp1Result !== 4 || rsp0Valid !== 1'b0) begin failures++; $display("FAIL both_rsp[%0d] got v1=%b r1=%0d v0=%b want 1 4 0", i, rsp1Valid, rsp1Result, rsp0Valid); end
            end else begin
                checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 2 || rsp1Valid !== 1'b0) begin failures++; $display("FAIL both_rsp[%0d] got v0=%b r0=%0d v1=%b want 1 2 0", i, rsp0Valid, rsp0Result, rsp1Valid); end
            end
            tick();
        end
        req0Valid = 0; req1Valid = 0; rsp0Ready = 0; rsp1Ready = 0;
    endtask

    task automatic test_backpressure();
        req1Valid = 1; req1A = 10; req1B = 20; req1Op = 0; rsp1Ready = 0;
        #1;
        checks++; if (req1Ready !== 1'b1) begin failures++; $display("FAIL bp_accept got %b want 1", req1Ready); end
        tick();
        req1Valid = 0; req0Valid = 1; req0A = 100; req0B = 1; rsp0Ready = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (rsp1Valid !== 1'b1 || rsp1Result !== 30) begin failures++; $display("FAIL bp_hold[%0d] got v=%b r=%0d want 1 30", k, rsp1Valid, rsp1Result); end
            checks++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin failures++; $display("FAIL bp_no_ready[%0d] got r0=%b r1=%b want 0 0", k, req0Ready, req1Ready); end
            tick();
        end
        rsp1Ready = 1;
        tick();
        rsp1Ready = 0;
        #1;
        checks++; if (rsp1Valid !== 1'b0 || req0Ready !== 1'b1) begin failures++; $display("FAIL bp_release got v1=%b r0=%b want 0 1", rsp1Valid, req0Ready); end
        tick();
        req0Valid = 0;
        tick();
        checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 101) begin failures++; $display("FAIL bp_next got v=%b r=%0d want 1 101", rsp0Valid, rsp0Result); end
        tick();
        rsp0Ready = 0;
    endtask

    task automatic test_reset_in_hold();
        req0Valid = 1; req0A = 4; req0B = 4; req0Op = 3; rsp0Ready = 0;
        tick();
        req0Valid = 0;
        tick();
        checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 8) begin failures++; $display("FAIL rh_hold got v=%b r=%0d want 1 8", rsp0Valid, rsp0Result); end
        reset = 1'b1;
        #1;
        checks++; if (rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0 || rsp0Result !== 0 || rsp1Result !== 0) begin failures++; $display("FAIL rh_async got v=%b%b r0=%0d r1=%0d want 0", rsp0Valid, rsp1Valid, rsp0Result, rsp1Result); end
        checks++; if (aluA !== 0 || aluB !== 0 || aluOp !== 0 || grantId !== 0) begin failures++; $display("FAIL rh_regs got a=%0d b=%0d op=%0d g=%0d want 0", aluA, aluB, aluOp, grantId); end
        tick();
        reset = 1'b0;
        req0Valid = 1; req0A = 6; req0B = 9; req0Op = 0; rsp0Ready = 1;
        #1;
        checks++; if (req0Ready !== 1'b1) begin failures++; $display("FAIL rh_first_idle got %b want 1", req0Ready); end
        tick();
        req0Valid = 0;
        tick();
        checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 15) begin failures++; $display("FAIL rh_after got v=%b r=%0d want 1 15", rsp0Valid, rsp0Result); end
        tick();
        rsp0Ready = 0;
    endtask

    task automatic test_operand_change();
        req0Valid = 1; req0A = 3; req0B = 1; req0Op = 5; rsp0Ready = 1;
        tick();
        req0Valid = 0; req0A = 9;
        #1;
        checks++; if (aluA !== 3 || aluOp !== 5) begin failures++; $display("FAIL oc_alu got a=%0d op=%0d want 3 5", aluA, aluOp); end
        tick();
        checks++; if (rsp0Valid !== 1'b1 || rsp0Result !== 4) begin failures++; $display("FAIL oc_result got v=%b r=%0d want 1 4", rsp0Valid, rsp0Result); end
        tick();
        rsp0Ready = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_port0_alone();
        test_both_valid();
        test_backpressure();
        test_reset_in_hold();
        test_operand_change();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
